// File: rtl/rtc_pkg.sv
// Shared RTC field constants and BCD helpers.
// Used by every time/date field counter.
package rtc_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] FIELD_SS_U = 4'd0;
  localparam logic [3:0] FIELD_SS_T = 4'd1;
  localparam logic [3:0] FIELD_MM_U = 4'd2;
  localparam logic [3:0] FIELD_MM_T = 4'd3;
  localparam logic [3:0] FIELD_HH_U = 4'd9;
  localparam logic [3:0] FIELD_HH_T = 4'd10;

  function automatic logic [2*BCD_W-1:0] int_to_bcd(input int v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] u;
    t = BCD_W'(v / 10);
    u = BCD_W'(v % 10);
    return {t, u};
  endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector; history resets to 1 so a level held
// across reset release is not seen as an edge.
module pulse_edge_detect #(
  parameter int EDGE_MODE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_d;

  always_ff @(posedge clk) begin
    if (reset) din_d <= 1'b1;
    else       din_d <= din;
  end

  if (EDGE_MODE != 0) begin : g_edge
    assign pulse = din & ~din_d;
  end else begin : g_level
    assign pulse = din;
  end

endmodule

// File: rtl/contador_bcd_ad_param.sv
// Two-digit BCD up/down counter for one RTC field, with
// parallel load, cascade tick and wrap carry/borrow pulses.
module contador_bcd_ad_param
  import rtc_pkg::*;
#(
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 23,
  parameter int FIELD_ID  = 10,
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_count,
  input  logic       enUP,
  input  logic       enDOWN,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tick,
  output logic [7:0] data_bcd,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       load_err
);

  if (MAX_VAL > 99 || MIN_VAL < 0 || MIN_VAL > MAX_VAL)
  begin : g_bad_params
    $error("contador_bcd_ad_param: illegal MIN_VAL/MAX_VAL");
  end

  localparam logic [7:0] MIN_BCD = int_to_bcd(MIN_VAL);
  localparam logic [7:0] MAX_BCD = int_to_bcd(MAX_VAL);
  localparam logic [3:0] SEL_ID  = 4'(FIELD_ID);

  function automatic logic legal(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
           (v >= MIN_BCD) && (v <= MAX_BCD);
  endfunction

  logic up_p;
  logic dn_p;
  logic sel;
  logic man_up;
  logic man_dn;
  logic do_inc;
  logic [7:0] inc_val;
  logic [7:0] dec_val;

  pulse_edge_detect #(.EDGE_MODE(EDGE_MODE)) u_up (
    .clk   (clk),
    .reset (reset),
    .din   (enUP),
    .pulse (up_p)
  );

  pulse_edge_detect #(.EDGE_MODE(EDGE_MODE)) u_dn (
    .clk   (clk),
    .reset (reset),
    .din   (enDOWN),
    .pulse (dn_p)
  );

  assign sel    = (en_count == SEL_ID);
  assign man_up = sel & up_p & ~dn_p;
  assign man_dn = sel & dn_p & ~up_p;
  assign do_inc = tick | man_up;

  always_comb begin
    inc_val = data_bcd;
    dec_val = data_bcd;
    if (data_bcd[3:0] == 4'd9)
      inc_val = {data_bcd[7:4] + 4'd1, 4'd0};
    else
      inc_val = {data_bcd[7:4], data_bcd[3:0] + 4'd1};
    if (data_bcd[3:0] == 4'd0)
      dec_val = {data_bcd[7:4] - 4'd1, 4'd9};
    else
      dec_val = {data_bcd[7:4], data_bcd[3:0] - 4'd1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_bcd   <= MIN_BCD;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
      // Recover from any corrupted state before anything else.
      if (!legal(data_bcd)) begin
        data_bcd <= MIN_BCD;
      end else if (load) begin
        if (legal(load_data)) data_bcd <= load_data;
        else                  load_err <= 1'b1;
      end else if (do_inc) begin
        if (data_bcd == MAX_BCD) begin
          data_bcd  <= MIN_BCD;
          carry_out <= 1'b1;
        end else begin
          data_bcd <= inc_val;
        end
      end else if (man_dn) begin
        if (data_bcd == MIN_BCD) begin
          data_bcd   <= MAX_BCD;
          borrow_out <= 1'b1;
        end else begin
          data_bcd <= dec_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_bcd_ad_param.sv
// Directed bench: three counter configurations on shared inputs,
// each step checks the instance it targets.
module tb_contador_bcd_ad_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       load;
  logic [7:0] load_data;
  logic       tick;

  logic [7:0] d0, d1, d2;
  logic       c0, c1, c2;
  logic       b0, b1, b2;
  logic       e0, e1, e2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  contador_bcd_ad_param #(
    .MIN_VAL(0), .MAX_VAL(23), .FIELD_ID(10), .EDGE_MODE(1)
  ) u0 (
    .clk(clk), .reset(reset), .en_count(en_count),
    .enUP(enUP), .enDOWN(enDOWN), .load(load),
    .load_data(load_data), .tick(tick), .data_bcd(d0),
    .carry_out(c0), .borrow_out(b0), .load_err(e0)
  );

  contador_bcd_ad_param #(
    .MIN_VAL(1), .MAX_VAL(12), .FIELD_ID(10), .EDGE_MODE(1)
  ) u1 (
    .clk(clk), .reset(reset), .en_count(en_count),
    .enUP(enUP), .enDOWN(enDOWN), .load(load),
    .load_data(load_data), .tick(tick), .data_bcd(d1),
    .carry_out(c1), .borrow_out(b1), .load_err(e1)
  );

  contador_bcd_ad_param #(
    .MIN_VAL(0), .MAX_VAL(23), .FIELD_ID(10), .EDGE_MODE(0)
  ) u2 (
    .clk(clk), .reset(reset), .en_count(en_count),
    .enUP(enUP), .enDOWN(enDOWN), .load(load),
    .load_data(load_data), .tick(tick), .data_bcd(d2),
    .carry_out(c2), .borrow_out(b2), .load_err(e2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_data = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en_count = 4'd10;
    enUP = 1'b0;
    enDOWN = 1'b0;
    load = 1'b0;
    load_data = 8'h00;
    tick = 1'b0;
    cyc();
    cyc();
    chk("rst_d0", d0, 8'h00);
    chk("rst_d1", d1, 8'h01);
    chk("rst_c0", {7'd0, c0}, 8'h00);
    chk("rst_b0", {7'd0, b0}, 8'h00);
    chk("rst_e0", {7'd0, e0}, 8'h00);
    reset = 1'b0;
    cyc();

    // up-wrap 23 -> 00
    do_load(8'h23);
    chk("ld23_d0", d0, 8'h23);
    chk("ld23_e1", {7'd0, e1}, 8'h01);
    enUP = 1'b1;
    cyc();
    chk("wrap_d0", d0, 8'h00);
    chk("wrap_c0", {7'd0, c0}, 8'h01);
    chk("wrap_b0", {7'd0, b0}, 8'h00);
    enUP = 1'b0;
    cyc();
    chk("wrap_c0_end", {7'd0, c0}, 8'h00);

    // down-wrap on MIN=1 MAX=12
    do_load(8'h01);
    enDOWN = 1'b1;
    cyc();
    chk("bwrap_d1", d1, 8'h12);
    chk("bwrap_b1", {7'd0, b1}, 8'h01);
    chk("bwrap_c1", {7'd0, c1}, 8'h00);
    enDOWN = 1'b0;
    cyc();
    chk("bwrap_b1_end", {7'd0, b1}, 8'h00);
    do_load(8'h10);
    enDOWN = 1'b1;
    cyc();
    chk("dec10_d1", d1, 8'h09);
    chk("dec10_d0", d0, 8'h09);
    enDOWN = 1'b0;
    cyc();

    // load validation on u0 (currently 09)
    do_load(8'h1A);
    chk("ld1A_d0", d0, 8'h09);
    chk("ld1A_e0", {7'd0, e0}, 8'h01);
    do_load(8'h25);
    chk("ld25_d0", d0, 8'h09);
    chk("ld25_e0", {7'd0, e0}, 8'h01);
    do_load(8'h17);
    chk("ld17_d0", d0, 8'h17);
    chk("ld17_e0", {7'd0, e0}, 8'h00);
    chk("ld17_c0", {7'd0, c0}, 8'h00);

    // held request: edge mode vs level mode
    do_load(8'h05);
    enUP = 1'b1;
    repeat (10) cyc();
    chk("hold_edge_d0", d0, 8'h06);
    chk("hold_lvl_d2", d2, 8'h15);
    enUP = 1'b0;
    cyc();

    // not selected
    en_count = 4'd3;
    enUP = 1'b1;
    cyc();
    enUP = 1'b0;
    cyc();
    enUP = 1'b1;
    cyc();
    enUP = 1'b0;
    cyc();
    chk("nosel_d0", d0, 8'h06);
    chk("nosel_d2", d2, 8'h15);
    en_count = 4'd10;

    // simultaneous up and down: no step
    enUP = 1'b1;
    enDOWN = 1'b1;
    cyc();
    chk("updn_d0", d0, 8'h06);
    enUP = 1'b0;
    enDOWN = 1'b0;
    cyc();

    // tick wins over manual down
    do_load(8'h09);
    tick = 1'b1;
    enDOWN = 1'b1;
    cyc();
    chk("tick_dn_d0", d0, 8'h10);
    tick = 1'b0;
    enDOWN = 1'b0;
    do_load(8'h23);
    tick = 1'b1;
    cyc();
    chk("tick_wrap_d0", d0, 8'h00);
    chk("tick_wrap_c0", {7'd0, c0}, 8'h01);
    tick = 1'b0;
    cyc();

    // reset with request held high
    do_load(8'h14);
    chk("ld14_d0", d0, 8'h14);
    enUP = 1'b1;
    reset = 1'b1;
    cyc();
    chk("rst_hold_d0", d0, 8'h00);
    cyc();
    reset = 1'b0;
    cyc();
    chk("rel1_d0", d0, 8'h00);
    cyc();
    chk("rel2_d0", d0, 8'h00);
    enUP = 1'b0;
    cyc();

    // reset beats load
    reset = 1'b1;
    load = 1'b1;
    load_data = 8'h17;
    cyc();
    chk("rst_ld_d0", d0, 8'h00);
    chk("rst_ld_e0", {7'd0, e0}, 8'h00);
    reset = 1'b0;
    load = 1'b0;
    cyc();
    chk("rst_ld_after", d0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
